// File: rtl/instr_sequencer.sv
// Program-counter / IR / step-counter front end for control_unit.
// Fetches from a synchronous ROM, counts execution steps and halts after LAST_ADDR.
module instr_sequencer #(
  parameter int IR_W      = 9,
  parameter int ADDR_W    = 5,
  parameter int LAST_ADDR = 31
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic              IRin,
  input  logic              done,
  input  logic              clear,
  input  logic [IR_W-1:0]   mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [IR_W-1:0]   IR,
  output logic [1:0]        counter,
  output logic              busy,
  output logic              halted,
  output logic              stall_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(LAST_ADDR);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [IR_W-1:0]   r_ir;
  logic [1:0]        r_counter;
  logic              r_stall_err;

  state_t            w_state_nxt;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [IR_W-1:0]   w_ir_nxt;
  logic [1:0]        w_counter_nxt;
  logic              w_stall_set;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_pc        <= '0;
      r_ir        <= '0;
      r_counter   <= 2'd0;
      r_stall_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_counter   <= w_counter_nxt;
      r_stall_err <= r_stall_err | w_stall_set;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_ir_nxt      = r_ir;
    w_counter_nxt = r_counter;
    // A stalled step is flagged regardless of a simultaneous flush.
    w_stall_set   = (r_state == EXEC) && (r_counter == 2'd3) && !done;

    if (IRin && (r_state != IDLE)) begin
      w_ir_nxt = mem_data;
    end

    case (r_state)
      IDLE: begin
        w_counter_nxt = 2'd0;
        if (run) begin
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        w_counter_nxt = 2'd0;
        w_state_nxt   = EXEC;
      end
      EXEC: begin
        if (done) begin
          w_counter_nxt = 2'd0;
          if (r_pc == LP_LAST) begin
            w_state_nxt = HALT;
          end else begin
            w_pc_nxt    = r_pc + ADDR_W'(1);
            w_state_nxt = run ? FETCH : IDLE;
          end
        end else if (r_counter != 2'd3) begin
          w_counter_nxt = r_counter + 2'd1;
        end
      end
      HALT: begin
        w_counter_nxt = 2'd0;
        if (!run) begin
          w_state_nxt = IDLE;
          w_pc_nxt    = '0;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_counter_nxt = 2'd0;
      end
    endcase

    // Flush overrides every other update in the same cycle.
    if (clear) begin
      w_state_nxt   = IDLE;
      w_counter_nxt = 2'd0;
      w_pc_nxt      = '0;
      w_ir_nxt      = '0;
    end
  end

  assign mem_addr  = r_pc;
  assign IR        = r_ir;
  assign counter   = r_counter;
  assign busy      = (r_state != IDLE);
  assign halted    = (r_state == HALT);
  assign stall_err = r_stall_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed vector table, hand sequences for multi-cycle
// corners, and random stimulus against a behavioural model for two LAST_ADDR settings.
module tb_instr_sequencer;

  typedef struct packed {
    logic [1:0] cnt;
    logic [4:0] addr;
    logic       busy;
    logic       halt;
    logic [8:0] ir;
    logic       stall;
  } obs_t;

  typedef struct {
    logic  run;
    logic  irin;
    logic  done;
    logic  clr;
    obs_t  exp;
    string name;
  } vec_t;

  // Program-level view: running or not, halted or not, and which step (-1 = fetch).
  typedef struct {
    bit         active;
    bit         halt;
    int         step;
    int         pc;
    int         last;
    logic [8:0] ir;
    bit         stall;
    logic [8:0] mdata;
  } model_t;

  localparam logic [8:0] R0 = 9'b001_000_001;
  localparam logic [8:0] R1 = 9'b100_010_000;
  localparam logic [8:0] R2 = 9'b010_011_100;

  logic       clock;
  logic       resetn;
  logic       run, irin, done, clr;
  logic [8:0] rom [32];

  logic [8:0] memDataA, memDataB;
  logic [4:0] memAddrA, memAddrB;
  logic [8:0] irA, irB;
  logic [1:0] cntA, cntB;
  logic       busyA, busyB, haltA, haltB, stallA, stallB;
  obs_t       obsA, obsB;

  int errCount   = 0;
  int checkCount = 0;

  instr_sequencer #(.IR_W(9), .ADDR_W(5), .LAST_ADDR(2)) dutA (
    .clock(clock), .resetn(resetn), .run(run), .IRin(irin), .done(done), .clear(clr),
    .mem_data(memDataA), .mem_addr(memAddrA), .IR(irA), .counter(cntA),
    .busy(busyA), .halted(haltA), .stall_err(stallA)
  );

  instr_sequencer dutB (
    .clock(clock), .resetn(resetn), .run(run), .IRin(irin), .done(done), .clear(clr),
    .mem_data(memDataB), .mem_addr(memAddrB), .IR(irB), .counter(cntB),
    .busy(busyB), .halted(haltB), .stall_err(stallB)
  );

  assign obsA = '{cnt: cntA, addr: memAddrA, busy: busyA, halt: haltA, ir: irA, stall: stallA};
  assign obsB = '{cnt: cntB, addr: memAddrB, busy: busyB, halt: haltB, ir: irB, stall: stallB};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROMs: data follows the address by one clock.
  always @(posedge clock) begin
    memDataA <= rom[memAddrA];
    memDataB <= rom[memAddrB];
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic obs_t mkObs(int c, int a, bit b, bit h, logic [8:0] i, bit s);
    obs_t o;
    o.cnt = 2'(c); o.addr = 5'(a); o.busy = b; o.halt = h; o.ir = i; o.stall = s;
    return o;
  endfunction

  function automatic vec_t mkVec(string n, bit r, bit i, bit d, bit c, obs_t e);
    vec_t v;
    v.name = n; v.run = r; v.irin = i; v.done = d; v.clr = c; v.exp = e;
    return v;
  endfunction

  function automatic model_t modelReset(int lastAddr);
    model_t m;
    m.active = 0; m.halt = 0; m.step = 0; m.pc = 0; m.last = lastAddr;
    m.ir = '0; m.stall = 0; m.mdata = rom[0];
    return m;
  endfunction

  function automatic model_t modelStep(model_t m, bit r, bit i, bit d, bit c);
    model_t n = m;
    n.mdata = rom[m.pc];
    if (m.active && !m.halt && m.step == 3 && !d) n.stall = 1;
    if (c) begin
      n.active = 0; n.halt = 0; n.step = 0; n.pc = 0; n.ir = '0;
    end else begin
      if (i && m.active) n.ir = m.mdata;
      if (!m.active) begin
        if (r) begin n.active = 1; n.step = -1; end
      end else if (m.halt) begin
        if (!r) begin n.active = 0; n.halt = 0; n.pc = 0; end
      end else if (m.step < 0) begin
        n.step = 0;
      end else if (d) begin
        if (m.pc == m.last) begin
          n.halt = 1;
        end else begin
          n.pc = (m.pc + 1) % 32;
          if (r) n.step = -1;
          else n.active = 0;
        end
      end else begin
        n.step = (m.step < 3) ? m.step + 1 : 3;
      end
    end
    return n;
  endfunction

  function automatic obs_t modelObs(model_t m);
    int c = (m.active && !m.halt && m.step > 0) ? m.step : 0;
    return mkObs(c, m.pc, m.active, m.halt, m.ir, m.stall);
  endfunction

  task automatic applyStimulus(bit r, bit i, bit d, bit c);
    run = r; irin = i; done = d; clr = c;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(string name, obs_t act, obs_t exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got cnt=%0d addr=%0d busy=%b halt=%b ir=%b stall=%b, want cnt=%0d addr=%0d busy=%b halt=%b ir=%b stall=%b",
               name, act.cnt, act.addr, act.busy, act.halt, act.ir, act.stall,
               exp.cnt, exp.addr, exp.busy, exp.halt, exp.ir, exp.stall);
    end
  endtask

  task automatic stepCheck(string name, bit r, bit i, bit d, bit c, obs_t exp);
    applyStimulus(r, i, d, c);
    tick();
    checkOutput(name, obsA, exp);
  endtask

  task automatic resetDut();
    applyStimulus(0, 0, 0, 0);
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  vec_t   vecs[$];
  model_t mA, mB;

  initial begin
    for (int k = 0; k < 32; k++) rom[k] = 9'((k * 37 + 5) % 512);
    rom[0] = R0; rom[1] = R1; rom[2] = R2;

    vecs.push_back(mkVec("fetch",   1,0,0,0, mkObs(0,0,1,0,'0,0)));
    vecs.push_back(mkVec("exec0",   1,0,0,0, mkObs(0,0,1,0,'0,0)));
    vecs.push_back(mkVec("loadMV",  1,1,0,0, mkObs(1,0,1,0,R0,0)));
    vecs.push_back(mkVec("cnt2",    1,0,0,0, mkObs(2,0,1,0,R0,0)));
    vecs.push_back(mkVec("done2",   1,0,1,0, mkObs(0,1,1,0,R0,0)));
    vecs.push_back(mkVec("exec1",   1,0,0,0, mkObs(0,1,1,0,R0,0)));
    vecs.push_back(mkVec("loadMVI", 1,1,0,0, mkObs(1,1,1,0,R1,0)));
    vecs.push_back(mkVec("add2",    1,0,0,0, mkObs(2,1,1,0,R1,0)));
    vecs.push_back(mkVec("add3",    1,0,0,0, mkObs(3,1,1,0,R1,0)));
    vecs.push_back(mkVec("done3",   1,0,1,0, mkObs(0,2,1,0,R1,0)));
    vecs.push_back(mkVec("exec2",   1,0,0,0, mkObs(0,2,1,0,R1,0)));
    vecs.push_back(mkVec("load2",   1,1,0,0, mkObs(1,2,1,0,R2,0)));
    vecs.push_back(mkVec("halt",    1,0,1,0, mkObs(0,2,1,1,R2,0)));
    vecs.push_back(mkVec("haltHold",1,0,0,0, mkObs(0,2,1,1,R2,0)));
    vecs.push_back(mkVec("unhalt",  0,0,0,0, mkObs(0,0,0,0,R2,0)));
    vecs.push_back(mkVec("idleIgn", 0,1,1,0, mkObs(0,0,0,0,R2,0)));
    vecs.push_back(mkVec("restart", 1,0,0,0, mkObs(0,0,1,0,R2,0)));
    vecs.push_back(mkVec("rexec",   1,0,0,0, mkObs(0,0,1,0,R2,0)));
    vecs.push_back(mkVec("rload",   1,1,0,0, mkObs(1,0,1,0,R0,0)));

    // Asynchronous reset while executing.
    resetDut();
    stepCheck("rFetch", 1,0,0,0, mkObs(0,0,1,0,'0,0));
    stepCheck("rExec",  1,0,0,0, mkObs(0,0,1,0,'0,0));
    stepCheck("rLoad",  1,1,0,0, mkObs(1,0,1,0,R0,0));
    stepCheck("rDone",  1,0,1,0, mkObs(0,1,1,0,R0,0));
    stepCheck("rExec1", 1,0,0,0, mkObs(0,1,1,0,R0,0));
    stepCheck("rCnt1",  1,0,0,0, mkObs(1,1,1,0,R0,0));
    stepCheck("rCnt2",  1,0,0,0, mkObs(2,1,1,0,R0,0));
    resetn = 1'b0;
    #1;
    checkOutput("asyncReset", obsA, mkObs(0,0,0,0,'0,0));

    // Start latency, advance, halt and restart.
    resetDut();
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].run, vecs[v].irin, vecs[v].done, vecs[v].clr);
      tick();
      checkOutput(vecs[v].name, obsA, vecs[v].exp);
    end

    // Stall at counter=3, then flush keeps the sticky flag.
    stepCheck("stall2",  1,0,0,0, mkObs(2,0,1,0,R0,0));
    stepCheck("stall3",  1,0,0,0, mkObs(3,0,1,0,R0,0));
    stepCheck("stallA",  1,0,0,0, mkObs(3,0,1,0,R0,1));
    stepCheck("stallB",  1,0,0,0, mkObs(3,0,1,0,R0,1));
    stepCheck("stallC",  1,0,0,0, mkObs(3,0,1,0,R0,1));
    stepCheck("stallClr",1,0,0,1, mkObs(0,0,0,0,'0,1));

    // clear beats done and IRin on the same edge.
    resetDut();
    stepCheck("cFetch", 1,0,0,0, mkObs(0,0,1,0,'0,0));
    stepCheck("cExec",  1,0,0,0, mkObs(0,0,1,0,'0,0));
    stepCheck("cDone",  1,0,1,0, mkObs(0,1,1,0,'0,0));
    stepCheck("cExec1", 1,0,0,0, mkObs(0,1,1,0,'0,0));
    stepCheck("cLoad",  1,1,0,0, mkObs(1,1,1,0,R1,0));
    stepCheck("clrDone",1,1,1,1, mkObs(0,0,0,0,'0,0));

    // run dropped mid-instruction: completes, then idles at pc+1.
    stepCheck("dFetch", 1,0,0,0, mkObs(0,0,1,0,'0,0));
    stepCheck("dExec",  1,0,0,0, mkObs(0,0,1,0,'0,0));
    stepCheck("dCnt1",  1,0,0,0, mkObs(1,0,1,0,'0,0));
    stepCheck("dCnt2",  0,0,0,0, mkObs(2,0,1,0,'0,0));
    stepCheck("dCnt3",  0,0,0,0, mkObs(3,0,1,0,'0,0));
    stepCheck("dDone",  0,0,1,0, mkObs(0,1,0,0,'0,0));
    stepCheck("dIdle",  0,0,0,0, mkObs(0,1,0,0,'0,0));

    // Random stimulus against the program-level model.
    resetDut();
    mA = modelReset(2);
    mB = modelReset(31);
    begin
      bit r = 1;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(7) == 0) r = !r;
        applyStimulus(r, $urandom_range(1) == 1, $urandom_range(2) == 0,
                      $urandom_range(39) == 0);
        tick();
        mA = modelStep(mA, run, irin, done, clr);
        mB = modelStep(mB, run, irin, done, clr);
        checkOutput("randA", obsA, modelObs(mA));
        checkOutput("randB", obsB, modelObs(mB));
      end
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
